// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate cache controller between a
// single-cycle core's data port and a slow word-wide memory with ready handshake.
module cache_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFSET_W);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state, state_next;

  logic [TAG_W-1:0]    tag_arr  [LINES];
  logic [31:0]         data_arr [WORDS];
  logic [LINES-1:0]    valid;

  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [OFFSET_W-1:0] k;

  logic [TAG_W-1:0]    cpu_tag, q_tag;
  logic [INDEX_W-1:0]  cpu_index, q_index;
  logic                hit, q_hit, last_word;

  assign cpu_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_index = cpu_addr[OFFSET_W +: INDEX_W];
  assign q_tag     = addr_q[ADDR_W-1 -: TAG_W];
  assign q_index   = addr_q[OFFSET_W +: INDEX_W];

  assign hit       = valid[cpu_index] && (tag_arr[cpu_index] == cpu_tag);
  assign q_hit     = valid[q_index] && (tag_arr[q_index] == q_tag);
  assign last_word = (k == '1);
  assign cpu_rdata = data_arr[cpu_addr[INDEX_W+OFFSET_W-1:0]];

  // NOTE: sequential state always uses non-blocking <= so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_wr) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
          end else if (cpu_rd && !hit) begin
            addr_q <= cpu_addr;
            k      <= '0;
          end
        end
        REFILL: if (mem_ready) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  // Valid is set only when the last word lands, so an aborted refill leaves the line invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              valid <= '0;
    else if (state == REFILL && mem_ready && last_word)   valid[q_index] <= 1'b1;
  end

  // NOTE: tag and data arrays carry no reset; valid bits alone qualify their
  // contents, which keeps them mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready) begin
      data_arr[{q_index, k}] <= mem_rdata;
      if (last_word) tag_arr[q_index] <= q_tag;
    end
    if (state == WRITE && mem_ready && q_hit)
      data_arr[addr_q[INDEX_W+OFFSET_W-1:0]] <= wdata_q;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_wr)               state_next = WRITE;
        else if (cpu_rd && !hit)  state_next = REFILL;
      end
      REFILL:  if (mem_ready && last_word) state_next = IDLE;
      WRITE:   if (mem_ready)              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    case (state)
      IDLE:   stall = cpu_wr | (cpu_rd & !hit);
      REFILL: begin
        mem_rd   = 1'b1;
        mem_addr = {q_tag, q_index, k};
        stall    = 1'b1;
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        stall     = !mem_ready;
      end
      default: ;
    endcase
    if (rst) stall = 1'b0;
  end

endmodule
